// File: rtl/tinyv_pkg.sv
// tinyv_pkg
// Shared definitions for the TinyV multicycle core: opcode, FSM state and
// trap-cause enums, instruction field positions, and the small ALU used in
// the EXEC state.
package tinyv_pkg;

  localparam int INSTR_WIDTH = 32;

  // Instruction field positions (5-bit register fields, 16-bit immediate,
  // 26-bit jump index, 6-bit opcode in the low bits).
  localparam int OPC_W   = 6;
  localparam int RS1_LSB = 27;
  localparam int RS2_LSB = 22;
  localparam int RD_LSB  = 17;
  localparam int IMM_LSB = 6;
  localparam int IDX_LSB = 6;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_SLT  = 6'h06,
    OP_ADDI = 6'h07,
    OP_LW   = 6'h08,
    OP_SW   = 6'h09,
    OP_BEQ  = 6'h0A,
    OP_J    = 6'h0B,
    OP_JAL  = 6'h0C,
    OP_HALT = 6'h0D
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    TC_ILLEGAL  = 2'd0,
    TC_MISALIGN = 2'd1,
    TC_TIMEOUT  = 2'd2
  } trap_cause_e;

  function automatic logic isLegal(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic isRType(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Everything that is not a logic/compare op (ADD, ADDI, LW/SW address)
  // falls through to an add.
  function automatic logic [31:0] aluOp(input logic [5:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile
// Register file for the TinyV core: two asynchronous read ports, one
// synchronous write port, register 0 reads as zero and ignores writes.
// Ports:
//   clk, reset            clock, asynchronous active-high reset (clears all)
//   i_rdAddrA/o_rdDataA   read port A
//   i_rdAddrB/o_rdDataB   read port B
//   i_wrEn/i_wrAddr/i_wrData  write port
module mc_regfile
  import tinyv_pkg::*;
#(
  parameter int NUM_REGS = 32,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rdAddrA,
  output logic [31:0]      o_rdDataA,
  input  logic [IDX_W-1:0] i_rdAddrB,
  output logic [31:0]      o_rdDataB,
  input  logic             i_wrEn,
  input  logic [IDX_W-1:0] i_wrAddr,
  input  logic [31:0]      i_wrData
);

  logic [31:0] r_regs [NUM_REGS];

  // Writes to register 0 are dropped so it always holds zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wrEn && (i_wrAddr != '0)) begin
      r_regs[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdDataA = (i_rdAddrA == '0) ? 32'd0 : r_regs[i_rdAddrA];
  assign o_rdDataB = (i_rdAddrB == '0) ? 32'd0 : r_regs[i_rdAddrB];

endmodule

// File: rtl/mc_core_hs.sv
// mc_core_hs
// Multicycle TinyV core with a valid/ack memory handshake, request timeout,
// halt/trap terminal states and a retired-instruction counter.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   mem_req/mem_we          request valid, 1 = store
//   mem_addr/mem_wdata      byte address (low ADDR_WIDTH bits), store data
//   mem_rdata/mem_ack       read data and request completion
//   halted/trap/trap_cause  terminal status (cause 0 illegal, 1 misaligned,
//                           2 bus timeout)
//   instret/pc_dbg          retired-instruction count, current PC
module mc_core_hs
  import tinyv_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          NUM_REGS    = 32,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  halted,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [31:0]           instret,
  output logic [31:0]           pc_dbg
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int TO_W  = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(NUM_REGS - 1);

  state_e      r_state, w_nextState;
  trap_cause_e r_trapCause, w_nextCause;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_d, r_dm, r_instret;
  logic [TO_W-1:0] r_toCnt;
  logic r_runEn, r_halted, r_trap;

  logic [5:0]       w_op;
  logic [IDX_W-1:0] w_rs1Idx, w_rs2Idx, w_rdIdx;
  logic [31:0]      w_imm, w_aluB, w_execResult, w_rfA, w_rfB, w_rfWdata;
  logic             w_isLW, w_isSW, w_isJump, w_misaligned, w_reqState;
  logic             w_ackSeen, w_timeout, w_retire, w_rfWe;
  logic [IDX_W-1:0] w_rfWaddr;

  assign w_op     = r_ir[OPC_W-1:0];
  assign w_rs1Idx = r_ir[RS1_LSB +: IDX_W];
  assign w_rs2Idx = r_ir[RS2_LSB +: IDX_W];
  assign w_rdIdx  = r_ir[RD_LSB +: IDX_W];
  assign w_imm    = {{16{r_ir[IMM_LSB+15]}}, r_ir[IMM_LSB +: 16]};
  assign w_isLW   = (w_op == OP_LW);
  assign w_isSW   = (w_op == OP_SW);
  assign w_isJump = (w_op == OP_J) || (w_op == OP_JAL);

  // R-type ops take B; ADDI and the LW/SW address take the immediate.
  // JAL reuses D to carry its link value, the already-incremented PC.
  assign w_aluB       = isRType(w_op) ? r_b : w_imm;
  assign w_execResult = (w_op == OP_JAL) ? r_pc : aluOp(w_op, r_a, w_aluB);

  // A misaligned data access traps before the bus ever sees it.
  // r_runEn holds the bus quiet for the first cycle after reset so mem_req
  // is low while reset is asserted even though the state is FETCH.
  assign w_misaligned = (r_d[1:0] != 2'b00);
  assign w_reqState   = (r_state == S_FETCH) || ((r_state == S_MEM) && !w_misaligned);
  assign mem_req      = r_runEn && w_reqState;
  assign mem_we       = mem_req && (r_state == S_MEM) && w_isSW;
  assign mem_addr     = (r_state == S_MEM) ? r_d[ADDR_WIDTH-1:0] : r_pc[ADDR_WIDTH-1:0];
  assign mem_wdata    = r_b;
  assign w_ackSeen    = mem_req && mem_ack;
  assign w_timeout    = mem_req && !mem_ack && (r_toCnt == TO_LAST);

  assign halted     = r_halted;
  assign trap       = r_trap;
  assign trap_cause = r_trapCause;
  assign instret    = r_instret;
  assign pc_dbg     = r_pc;

  mc_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_rdAddrA (w_rs1Idx),
    .o_rdDataA (w_rfA),
    .i_rdAddrB (w_rs2Idx),
    .o_rdDataB (w_rfB),
    .i_wrEn    (w_rfWe),
    .i_wrAddr  (w_rfWaddr),
    .i_wrData  (w_rfWdata)
  );

  // Next-state, retire and register-write decode. An instruction retires in
  // the cycle it leaves its last state; HALT and trapped instructions don't.
  always_comb begin
    w_nextState = r_state;
    w_nextCause = r_trapCause;
    w_retire    = 1'b0;
    w_rfWe      = 1'b0;
    w_rfWaddr   = w_rdIdx;
    w_rfWdata   = r_d;
    case (r_state)
      S_FETCH: begin
        if (w_timeout) begin
          w_nextState = S_TRAP;
          w_nextCause = TC_TIMEOUT;
        end else if (w_ackSeen) begin
          w_nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!isLegal(w_op)) begin
          w_nextState = S_TRAP;
          w_nextCause = TC_ILLEGAL;
        end else if (w_op == OP_HALT) begin
          w_nextState = S_HALT;
        end else begin
          w_nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_isLW || w_isSW) begin
          w_nextState = S_MEM;
        end else if ((w_op == OP_BEQ) || (w_op == OP_J)) begin
          w_nextState = S_FETCH;
          w_retire    = 1'b1;
        end else begin
          w_nextState = S_WB;
        end
      end
      S_MEM: begin
        if (w_misaligned) begin
          w_nextState = S_TRAP;
          w_nextCause = TC_MISALIGN;
        end else if (w_timeout) begin
          w_nextState = S_TRAP;
          w_nextCause = TC_TIMEOUT;
        end else if (w_ackSeen) begin
          if (w_isLW) begin
            w_nextState = S_WB;
          end else begin
            w_nextState = S_FETCH;
            w_retire    = 1'b1;
          end
        end
      end
      S_WB: begin
        w_nextState = S_FETCH;
        w_retire    = 1'b1;
        w_rfWe      = 1'b1;
        if (w_isLW) begin
          w_rfWaddr = w_rs2Idx;
          w_rfWdata = r_dm;
        end else if (w_op == OP_ADDI) begin
          w_rfWaddr = w_rs2Idx;
        end else if (w_op == OP_JAL) begin
          w_rfWaddr = LINK_IDX;
        end
      end
      default: w_nextState = r_state;
    endcase
  end

  // State, datapath latches and counters. The timeout counter only runs
  // while a request is outstanding and clears on ack or when the bus idles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_trapCause <= TC_ILLEGAL;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_dm        <= '0;
      r_instret   <= '0;
      r_toCnt     <= '0;
      r_runEn     <= 1'b0;
      r_halted    <= 1'b0;
      r_trap      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_trapCause <= w_nextCause;
      r_runEn     <= 1'b1;
      r_toCnt     <= (mem_req && !mem_ack) ? r_toCnt + TO_W'(1) : '0;
      if (w_retire) r_instret <= r_instret + 32'd1;
      if (w_nextState == S_HALT) r_halted <= 1'b1;
      if (w_nextState == S_TRAP) r_trap <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (w_ackSeen) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a <= w_rfA;
          r_b <= w_rfB;
        end
        S_EXEC: begin
          r_d <= w_execResult;
          if ((w_op == OP_BEQ) && (r_a == r_b)) begin
            r_pc <= r_pc + {w_imm[29:0], 2'b00};
          end else if (w_isJump) begin
            r_pc <= {r_pc[31:28], r_ir[IDX_LSB +: 26], 2'b00};
          end
        end
        S_MEM: begin
          if (w_ackSeen && w_isLW) r_dm <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_hs.sv
// tb_mc_core_hs
// Scoreboard bench for mc_core_hs: each program pushes the memory
// transactions it should produce; a memory responder with configurable ack
// delay pops and compares them as the core completes requests.
module tb_mc_core_hs;
  import tinyv_pkg::*;

  logic        clk, reset;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        halted, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret, pc_dbg;

  mc_core_hs #(
    .ADDR_WIDTH  (16),
    .NUM_REGS    (32),
    .RESET_PC    (32'h0),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret),
    .pc_dbg     (pc_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [256];
  logic [64:0] expQ [$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          ackDelay   = 0;
  bit          neverAck   = 1'b0;
  int          waitCnt    = 0;
  bit          inReq      = 1'b0;
  int          stableErr  = 0;
  int          reqCycles  = 0;
  logic [15:0] reqAddr;
  logic        reqWe;
  logic [31:0] reqWdata;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {rs1, rs2, rd, 11'd0, op};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [15:0] imm);
    return {rs1, rs2, imm, op};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [25:0] idx);
    return {idx, op};
  endfunction

  task automatic pushTxn(input logic we, input logic [31:0] addr, input logic [31:0] data);
    expQ.push_back({we, addr, data});
  endtask

  // Completed transaction against the head of the scoreboard.
  task automatic scoreTxn();
    logic [64:0] e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_req", {16'h0, mem_addr}, 32'hFFFF_FFFF);
    end else begin
      e = expQ.pop_front();
      checkOutput("txn_addr", {16'h0, mem_addr}, e[63:32]);
      checkOutput("txn_we", {31'd0, mem_we}, {31'd0, e[64]});
      if (e[64]) checkOutput("txn_wdata", mem_wdata, e[31:0]);
    end
  endtask

  // Memory responder: samples the request on the falling edge, tracks
  // stability while waiting, and acks after ackDelay wait cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req !== 1'b1) begin
        inReq = 1'b0;
      end else begin
        reqCycles++;
        if (!inReq) begin
          inReq    = 1'b1;
          waitCnt  = 0;
          reqAddr  = mem_addr;
          reqWe    = mem_we;
          reqWdata = mem_wdata;
        end else if (mem_addr !== reqAddr || mem_we !== reqWe || mem_wdata !== reqWdata) begin
          stableErr++;
        end
        if (!neverAck && waitCnt >= ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          scoreTxn();
          inReq = 1'b0;
        end else begin
          waitCnt++;
        end
      end
    end
  end

  task automatic applyReset();
    reset = 1'b1;
    expQ.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input int delay, input bit noAck);
    ackDelay  = delay;
    neverAck  = noAck;
    stableErr = 0;
    reqCycles = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runToDone(input string tag, input int budget);
    int n = 0;
    while (!(halted || trap) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, {31'd0, halted | trap}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic loadProg1();
    mem[0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd5);
    mem[1] = encI(OP_ADDI, 5'd0, 5'd2, 16'd7);
    mem[2] = encR(OP_ADD, 5'd3, 5'd1, 5'd2);
    mem[3] = encI(OP_SW, 5'd0, 5'd3, 16'h0040);
    mem[4] = encJ(OP_HALT, 26'd0);
    pushTxn(1'b0, 32'h00, 32'h0);
    pushTxn(1'b0, 32'h04, 32'h0);
    pushTxn(1'b0, 32'h08, 32'h0);
    pushTxn(1'b0, 32'h0C, 32'h0);
    pushTxn(1'b1, 32'h40, 32'd12);
    pushTxn(1'b0, 32'h10, 32'h0);
  endtask

  task automatic checkProg1(input string tag);
    checkOutput({tag, "_halted"}, {31'd0, halted}, 32'd1);
    checkOutput({tag, "_trap"}, {31'd0, trap}, 32'd0);
    checkOutput({tag, "_instret"}, instret, 32'd4);
    checkOutput({tag, "_mem40"}, mem[16], 32'd12);
    checkOutput({tag, "_req_idle"}, {31'd0, mem_req}, 32'd0);
    checkOutput({tag, "_sb_empty"}, expQ.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_pc", pc_dbg, 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_status", {29'd0, halted, trap_cause}, 32'd0);

    // Zero-wait memory, basic ALU program with a store
    applyReset();
    loadProg1();
    applyStimulus(0, 1'b0);
    runToDone("p1", 200);
    checkProg1("p1");

    // Every request acked after 3 wait cycles
    applyReset();
    loadProg1();
    applyStimulus(3, 1'b0);
    runToDone("p1d", 400);
    checkProg1("p1d");
    checkOutput("p1d_stable", stableErr, 32'd0);

    // Branch taken/not-taken, JAL link, LW round trip
    applyReset();
    mem[0]  = encI(OP_ADDI, 5'd0, 5'd1, 16'd3);
    mem[1]  = encI(OP_ADDI, 5'd0, 5'd2, 16'd3);
    mem[2]  = encI(OP_ADDI, 5'd0, 5'd3, 16'd0);
    mem[3]  = encI(OP_ADDI, 5'd0, 5'd4, 16'd0);
    mem[4]  = encI(OP_BEQ, 5'd1, 5'd2, 16'd2);
    mem[7]  = encI(OP_ADDI, 5'd0, 5'd5, 16'd1);
    mem[8]  = encJ(OP_JAL, 26'd12);
    mem[12] = encI(OP_SW, 5'd0, 5'd31, 16'h0044);
    mem[13] = encI(OP_BEQ, 5'd1, 5'd5, 16'd4);
    mem[14] = encI(OP_LW, 5'd0, 5'd6, 16'h0044);
    mem[15] = encI(OP_SW, 5'd0, 5'd6, 16'h0048);
    mem[16] = encJ(OP_HALT, 26'd0);
    foreach (mem[i]) if (i <= 4 || i == 7 || i == 8 || i == 12 || i == 13) begin end
    pushTxn(1'b0, 32'h00, 0); pushTxn(1'b0, 32'h04, 0);
    pushTxn(1'b0, 32'h08, 0); pushTxn(1'b0, 32'h0C, 0);
    pushTxn(1'b0, 32'h10, 0); pushTxn(1'b0, 32'h1C, 0);
    pushTxn(1'b0, 32'h20, 0); pushTxn(1'b0, 32'h30, 0);
    pushTxn(1'b1, 32'h44, 32'h24);
    pushTxn(1'b0, 32'h34, 0); pushTxn(1'b0, 32'h38, 0);
    pushTxn(1'b0, 32'h44, 0); pushTxn(1'b0, 32'h3C, 0);
    pushTxn(1'b1, 32'h48, 32'h24);
    pushTxn(1'b0, 32'h40, 0);
    applyStimulus(1, 1'b0);
    runToDone("br", 400);
    checkOutput("br_halted", {31'd0, halted}, 32'd1);
    checkOutput("br_instret", instret, 32'd11);
    checkOutput("br_mem48", mem[18], 32'h24);
    checkOutput("br_sb_empty", expQ.size(), 32'd0);

    // Misaligned LW traps without requesting the bus
    applyReset();
    mem[0] = encI(OP_LW, 5'd0, 5'd2, 16'h0041);
    pushTxn(1'b0, 32'h00, 0);
    applyStimulus(0, 1'b0);
    runToDone("mis", 100);
    checkOutput("mis_trap", {31'd0, trap}, 32'd1);
    checkOutput("mis_cause", {30'd0, trap_cause}, 32'd1);
    checkOutput("mis_halted", {31'd0, halted}, 32'd0);
    checkOutput("mis_instret", instret, 32'd0);
    checkOutput("mis_req_idle", {31'd0, mem_req}, 32'd0);
    checkOutput("mis_sb_empty", expQ.size(), 32'd0);

    // Illegal opcode
    applyReset();
    mem[0] = 32'h0000_003F;
    pushTxn(1'b0, 32'h00, 0);
    applyStimulus(0, 1'b0);
    runToDone("ill", 100);
    checkOutput("ill_trap", {31'd0, trap}, 32'd1);
    checkOutput("ill_cause", {30'd0, trap_cause}, 32'd0);
    checkOutput("ill_sb_empty", expQ.size(), 32'd0);

    // Bus timeout: ack never arrives, MEM_TIMEOUT = 4
    applyReset();
    mem[0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd1);
    applyStimulus(0, 1'b1);
    runToDone("to", 100);
    checkOutput("to_trap", {31'd0, trap}, 32'd1);
    checkOutput("to_cause", {30'd0, trap_cause}, 32'd2);
    checkOutput("to_req_cycles", reqCycles, 32'd4);
    checkOutput("to_req_idle", {31'd0, mem_req}, 32'd0);

    // Reset while a fetch is waiting for its ack
    applyReset();
    loadProg1();
    applyStimulus(2, 1'b0);
    begin
      int n = 0;
      while (instret != 32'd2 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("mid_pre_instret", instret, 32'd2);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("mid_req", {31'd0, mem_req}, 32'd0);
    checkOutput("mid_pc", pc_dbg, 32'd0);
    checkOutput("mid_instret", instret, 32'd0);
    checkOutput("mid_status", {30'd0, halted, trap}, 32'd0);
    expQ.delete();
    loadProg1();
    applyStimulus(0, 1'b0);
    runToDone("mid", 200);
    checkProg1("mid");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
